// File: rtl/vga_dither_pkg.sv
// Shared constants for the VGA output stage: reduction modes, the 4x4 Bayer
// matrix and the helper that turns a matrix entry into a colour offset.
package vga_dither_pkg;

  localparam logic [1:0] MODE_TRUNC     = 2'd0;
  localparam logic [1:0] MODE_ROUND     = 2'd1;
  localparam logic [1:0] MODE_BAYER     = 2'd2;
  localparam logic [1:0] MODE_BAYER_ROT = 2'd3;

  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  // d is the number of LSBs dropped; the 4-bit matrix entry is aligned so its
  // MSB lands just below the lowest kept bit.
  function automatic logic [31:0] dither_offset(input logic [3:0] b, input int d,
                                                input logic [1:0] mode);
    logic [31:0] t;
    t = '0;
    case (mode)
      MODE_ROUND:                 t = 32'd1 << (d - 1);
      MODE_BAYER, MODE_BAYER_ROT: t = (d >= 4) ? ({28'd0, b} << (d - 4))
                                               : ({28'd0, b} >> (4 - d));
      default:                    t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/vga_dither_channel.sv
// One colour channel: add offset, saturate at full scale, keep the top OUT_W
// bits, and register the result as the second pipeline stage.
module dither_channel #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  pix_p1,
  input  logic [IN_W-1:0]  t_p1,
  output logic [OUT_W-1:0] out_p2
);
  localparam int D = IN_W - OUT_W;

  logic [OUT_W-1:0] out_p2_d, out_p2_q;

  // The carry bit means the sum overflowed; clamp instead of wrapping to black.
  function automatic logic [OUT_W-1:0] sat_trunc(input logic [IN_W:0] s);
    return s[IN_W] ? {OUT_W{1'b1}} : OUT_W'(s >> D);
  endfunction

  always_comb begin
    out_p2_d = sat_trunc({1'b0, pix_p1} + {1'b0, t_p1});
  end

  // stage 2
  always_ff @(posedge clk) begin
    if (rst) out_p2_q <= '0;
    else     out_p2_q <= out_p2_d;
  end

  assign out_p2 = out_p2_q;

endmodule

// File: rtl/vga_dither_out.sv
// VGA output stage: reduces IN_W-bit colour to OUT_W bits by truncation, rounding
// or ordered dither, keeping sync and colour aligned through a 2-cycle pipeline.
module vga_dither_out
  import vga_dither_pkg::*;
#(
  parameter int IN_W            = 8,
  parameter int OUT_W           = 4,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK_25MHZ,
  input  logic             RESET,
  input  logic [1:0]       MODE,
  input  logic             PIX_HSYNC,
  input  logic             PIX_VSYNC,
  input  logic [IN_W-1:0]  PIX_RED,
  input  logic [IN_W-1:0]  PIX_GREEN,
  input  logic [IN_W-1:0]  PIX_BLUE,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic [OUT_W-1:0] VGA_RED,
  output logic [OUT_W-1:0] VGA_GREEN,
  output logic [OUT_W-1:0] VGA_BLUE
);
  localparam int D = IN_W - OUT_W;

  logic            hs_act, vs_act, hs_edge, vs_edge;
  logic [1:0]      x_d, x_q, y_d, y_q, f_d, f_q, mode_d, mode_q, bx, by;
  logic            hs_p1_d, hs_p1_q, vs_p1_d, vs_p1_q;
  logic            hs_p2_d, hs_p2_q, vs_p2_d, vs_p2_q;
  logic [IN_W-1:0] red_p1_d, red_p1_q, green_p1_d, green_p1_q, blue_p1_d, blue_p1_q;
  logic [IN_W-1:0] t_p1_d, t_p1_q;

  always_comb begin
    // Syncs are handled internally as active-high; hs_p1_q/vs_p1_q double as
    // the edge-detect history.
    hs_act  = PIX_HSYNC ^ SYNC_ACTIVE_LOW;
    vs_act  = PIX_VSYNC ^ SYNC_ACTIVE_LOW;
    hs_edge = hs_act & ~hs_p1_q;
    vs_edge = vs_act & ~vs_p1_q;

    x_d = hs_edge ? 2'd0 : x_q + 2'd1;
    y_d = y_q;
    if (vs_edge)      y_d = 2'd0;
    else if (hs_edge) y_d = y_q + 2'd1;
    f_d    = vs_edge ? f_q + 2'd1 : f_q;
    mode_d = vs_edge ? MODE : mode_q;

    // The pixel on an edge cycle already sees the updated phase and mode.
    bx = x_d;
    by = y_d;
    if (mode_d == MODE_BAYER_ROT) begin
      bx = x_d + f_d;
      by = y_d + f_d;
    end
    t_p1_d = IN_W'(dither_offset(BAYER[by][bx], D, mode_d));

    hs_p1_d    = hs_act;
    vs_p1_d    = vs_act;
    red_p1_d   = PIX_RED;
    green_p1_d = PIX_GREEN;
    blue_p1_d  = PIX_BLUE;
    hs_p2_d    = hs_p1_q;
    vs_p2_d    = vs_p1_q;
  end

  // stage 1 (plus phase/mode state) and stage-2 syncs; reset flushes the pipe
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      x_q        <= '0;
      y_q        <= '0;
      f_q        <= '0;
      mode_q     <= MODE_TRUNC;
      hs_p1_q    <= 1'b0;
      vs_p1_q    <= 1'b0;
      red_p1_q   <= '0;
      green_p1_q <= '0;
      blue_p1_q  <= '0;
      t_p1_q     <= '0;
      hs_p2_q    <= 1'b0;
      vs_p2_q    <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      f_q        <= f_d;
      mode_q     <= mode_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
      red_p1_q   <= red_p1_d;
      green_p1_q <= green_p1_d;
      blue_p1_q  <= blue_p1_d;
      t_p1_q     <= t_p1_d;
      hs_p2_q    <= hs_p2_d;
      vs_p2_q    <= vs_p2_d;
    end
  end

  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_red (
    .clk(CLK_25MHZ), .rst(RESET), .pix_p1(red_p1_q), .t_p1(t_p1_q), .out_p2(VGA_RED)
  );
  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_green (
    .clk(CLK_25MHZ), .rst(RESET), .pix_p1(green_p1_q), .t_p1(t_p1_q), .out_p2(VGA_GREEN)
  );
  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_blue (
    .clk(CLK_25MHZ), .rst(RESET), .pix_p1(blue_p1_q), .t_p1(t_p1_q), .out_p2(VGA_BLUE)
  );

  assign VGA_HSYNC = hs_p2_q ^ SYNC_ACTIVE_LOW;
  assign VGA_VSYNC = vs_p2_q ^ SYNC_ACTIVE_LOW;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: directed vector table, a rotated-dither frame sweep,
// a mid-line reset, and randomized traffic against a behavioural model.
module tb_vga_dither_out;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       hs, vs;
  logic [7:0] r, g, b;
  logic       o_hs, o_vs, q_hs, q_vs;
  logic [3:0] o_r, o_g, o_b;
  logic [1:0] q_r, q_g, q_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_dither_out #(.IN_W(8), .OUT_W(4), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .CLK_25MHZ(clk), .RESET(rst), .MODE(mode), .PIX_HSYNC(hs), .PIX_VSYNC(vs),
    .PIX_RED(r), .PIX_GREEN(g), .PIX_BLUE(b),
    .VGA_HSYNC(o_hs), .VGA_VSYNC(o_vs), .VGA_RED(o_r), .VGA_GREEN(o_g), .VGA_BLUE(o_b)
  );

  vga_dither_out #(.IN_W(8), .OUT_W(2), .SYNC_ACTIVE_LOW(1'b1)) dut2 (
    .CLK_25MHZ(clk), .RESET(rst), .MODE(mode), .PIX_HSYNC(hs), .PIX_VSYNC(vs),
    .PIX_RED(r), .PIX_GREEN(g), .PIX_BLUE(b),
    .VGA_HSYNC(q_hs), .VGA_VSYNC(q_vs), .VGA_RED(q_r), .VGA_GREEN(q_g), .VGA_BLUE(q_b)
  );

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic hs, vs;
    int   c1r, c1g, c1b, c2r, c2g, c2b;
    int   tag;
  } exp_t;

  int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  exp_t cur_e, pend_e, rst_e;
  bit   m_hprev, m_vprev;
  int   mx, my, mf, mmode;
  int   cnt [16];

  function automatic int toff(input int bv, input int d, input int md);
    if (md == 0) return 0;
    if (md == 1) return 1 << (d - 1);
    if (d >= 4)  return bv << (d - 4);
    return bv >> (4 - d);
  endfunction

  function automatic int reduce(input int pix, input int t, input int d);
    int s;
    s = pix + t;
    if (s > 255) s = 255;
    return s >> d;
  endfunction

  task automatic model_edge(input logic h, input logic v, input logic [1:0] md,
                            input logic [7:0] pr, input logic [7:0] pg,
                            input logic [7:0] pb, input logic rs, input int tag);
    bit ha, va, he, ve;
    int bv, t1, t2;
    if (rs) begin
      m_hprev = 0; m_vprev = 0; mx = 0; my = 0; mf = 0; mmode = 0;
      cur_e = rst_e; pend_e = rst_e;
      return;
    end
    cur_e = pend_e;
    ha = !h; va = !v;
    he = ha && !m_hprev;
    ve = va && !m_vprev;
    mx = he ? 0 : (mx + 1) % 4;
    if (ve)      my = 0;
    else if (he) my = (my + 1) % 4;
    if (ve) begin
      mf = (mf + 1) % 4;
      mmode = int'(md);
    end
    m_hprev = ha; m_vprev = va;
    if (mmode == 3) bv = bay[(my + mf) % 4][(mx + mf) % 4];
    else            bv = bay[my][mx];
    t1 = toff(bv, 4, mmode);
    t2 = toff(bv, 6, mmode);
    pend_e = '{h, v, reduce(int'(pr), t1, 4), reduce(int'(pg), t1, 4), reduce(int'(pb), t1, 4),
               reduce(int'(pr), t2, 6), reduce(int'(pg), t2, 6), reduce(int'(pb), t2, 6), tag};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic [1:0] md,
                      input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                      input logic rs, input int tag);
    rst = rs; hs = h; vs = v; mode = md; r = pr; g = pg; b = pb;
    @(posedge clk);
    cyc++;
    model_edge(h, v, md, pr, pg, pb, rs, tag);
    #1;
    check("model_out4", {18'd0, o_hs, o_vs, o_r, o_g, o_b},
          {18'd0, cur_e.hs, cur_e.vs, 4'(cur_e.c1r), 4'(cur_e.c1g), 4'(cur_e.c1b)});
    check("model_out2", {24'd0, q_hs, q_vs, q_r, q_g, q_b},
          {24'd0, cur_e.hs, cur_e.vs, 2'(cur_e.c2r), 2'(cur_e.c2g), 2'(cur_e.c2b)});
    if (cur_e.tag >= 0 && o_r == 4'h9) cnt[cur_e.tag]++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       h, v;
    logic [1:0] md;
    logic [7:0] px;
    logic       eh, ev;
    logic [3:0] e1;
    logic [1:0] e2;
  } vec_t;

  vec_t tbl [12];

  initial begin
    rst_e = '{1'b1, 1'b1, 0, 0, 0, 0, 0, 0, -1};
    cur_e = rst_e; pend_e = rst_e;
    m_hprev = 0; m_vprev = 0; mx = 0; my = 0; mf = 0; mmode = 0;
    foreach (cnt[i]) cnt[i] = 0;
    rst = 1; hs = 1; vs = 1; mode = 0; r = 0; g = 0; b = 0;

    // truncate, mid-frame request for Bayer ignored, round with saturation,
    // then Bayer after the next vsync edge
    tbl[0]  = '{1, 1, 2'd0, 8'hA7, 1, 1, 4'hA, 2'd2};
    tbl[1]  = '{1, 1, 2'd2, 8'hA8, 1, 1, 4'hA, 2'd2};
    tbl[2]  = '{0, 1, 2'd2, 8'hFF, 0, 1, 4'hF, 2'd3};
    tbl[3]  = '{1, 0, 2'd1, 8'hA7, 1, 0, 4'hA, 2'd3};
    tbl[4]  = '{1, 0, 2'd2, 8'hA8, 1, 0, 4'hB, 2'd3};
    tbl[5]  = '{1, 1, 2'd2, 8'hFF, 1, 1, 4'hF, 2'd3};
    tbl[6]  = '{1, 1, 2'd2, 8'h37, 1, 1, 4'h3, 2'd1};
    tbl[7]  = '{1, 0, 2'd2, 8'h88, 1, 0, 4'h9, 2'd2};
    tbl[8]  = '{0, 1, 2'd2, 8'h88, 0, 1, 4'h9, 2'd2};
    tbl[9]  = '{0, 1, 2'd2, 8'h00, 0, 1, 4'h0, 2'd0};
    tbl[10] = '{1, 1, 2'd2, 8'hFF, 1, 1, 4'hF, 2'd3};
    tbl[11] = '{1, 1, 2'd2, 8'h88, 1, 1, 4'h8, 2'd2};

    for (int i = 0; i < 3; i++) step(1, 1, 2'd0, 8'h55, 8'h55, 8'h55, 1, -1);
    check("reset_state", {18'd0, o_hs, o_vs, o_r, o_g, o_b}, {18'd0, 2'b11, 12'h000});

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].h, tbl[i].v, tbl[i].md, tbl[i].px, tbl[i].px, tbl[i].px, 0, -1);
      if (i == 0)
        check("first_after_reset", {18'd0, o_hs, o_vs, o_r, o_g, o_b}, {18'd0, 2'b11, 12'h000});
      else
        check($sformatf("vec%0d", i - 1), {16'd0, o_hs, o_vs, o_r, o_g, o_b, q_r},
              {16'd0, tbl[i-1].eh, tbl[i-1].ev, {3{tbl[i-1].e1}}, tbl[i-1].e2});
    end
    step(1, 1, 2'd2, 8'h00, 8'h00, 8'h00, 0, -1);
    check("vec11", {16'd0, o_hs, o_vs, o_r, o_g, o_b, q_r},
          {16'd0, tbl[11].eh, tbl[11].ev, {3{tbl[11].e1}}, tbl[11].e2});

    // ---------------- rotated Bayer over four frames ----------------
    for (int i = 0; i < 2; i++) step(1, 1, 2'd3, 8'h88, 8'h88, 8'h88, 1, -1);
    for (int fr = 0; fr < 4; fr++) begin
      step(1, 0, 2'd3, 8'h88, 8'h88, 8'h88, 0, -1);
      for (int ln = 0; ln < 4; ln++) begin
        for (int px = 0; px < 4; px++)
          step(0, 1, 2'd3, 8'h88, 8'h88, 8'h88, 0, ((ln + 1) % 4) * 4 + px);
        step(1, 1, 2'd3, 8'h88, 8'h88, 8'h88, 0, -1);
      end
    end
    step(1, 1, 2'd3, 8'h88, 8'h88, 8'h88, 0, -1);
    step(1, 1, 2'd3, 8'h88, 8'h88, 8'h88, 0, -1);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        int want;
        want = 0;
        for (int f = 0; f < 4; f++) if (bay[(y + f) % 4][(x + f) % 4] >= 8) want++;
        check($sformatf("rot_count_x%0d_y%0d", x, y), 32'(cnt[y * 4 + x]), 32'(want));
      end
    end

    // ---------------- reset pulsed mid-line ----------------
    step(0, 1, 2'd2, 8'hC3, 8'h3C, 8'hFF, 0, -1);
    step(0, 1, 2'd2, 8'hC3, 8'h3C, 8'hFF, 0, -1);
    step(0, 1, 2'd2, 8'hC3, 8'h3C, 8'hFF, 1, -1);
    check("midline_reset", {18'd0, o_hs, o_vs, o_r, o_g, o_b}, {18'd0, 2'b11, 12'h000});
    step(0, 0, 2'd2, 8'h00, 8'hFF, 8'h88, 0, -1);
    step(0, 0, 2'd2, 8'h00, 8'hFF, 8'h88, 0, -1);
    step(1, 1, 2'd2, 8'h00, 8'hFF, 8'h88, 0, -1);
    check("out2_extremes", {28'd0, q_r, q_g}, {28'd0, 2'd0, 2'd3});

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 3000; i++) begin
      logic h, v, rs;
      logic [1:0] md;
      logic [7:0] pr, pg, pb;
      h  = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 40) != 0);
      rs = ($urandom_range(0, 150) == 0);
      md = 2'($urandom_range(0, 3));
      pr = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      pg = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? 8'hF8 : 8'($urandom);
      step(h, v, md, pr, pg, pb, rs, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
